// File: rtl/lfsr_arb_ctrl.sv
// rtl/lfsr_arb_ctrl.sv - round-robin sequencer sharing one 16-bit Fibonacci LFSR
//
// Purpose:
//   Shares one LFSR (shift left, feedback q15^q13^q12^q10) between NREQ
//   requesters. Each grant advances the LFSR STEPS times, then delivers the
//   word to the granted requester for one cycle. Grantees are chosen
//   round-robin.
//
// Ports:
//   clk        in   1     clock, posedge
//   reset      in   1     synchronous, active-high
//   req        in   NREQ  per-requester request level, sampled only in IDLE
//   seed_load  in   1     load seed_data into the LFSR (IDLE only)
//   seed_data  in   16    seed value; zero is replaced by SEED
//   gnt        out  NREQ  one-hot grant pulse, coincident with rnd_valid
//   rnd_valid  out  1     rnd_data valid pulse
//   rnd_data   out  16    delivered word, held between deliveries
//   busy       out  1     sequencer not idle
//   word_cnt   out  16    deliveries so far, wrapping (LFSR_ARB_STATS_EN only)
//
// Configuration macro: LFSR_ARB_STATS_EN adds the word_cnt output.
module lfsr_arb_ctrl #(
  parameter int          NREQ  = 4,
  parameter int          STEPS = 16,
  parameter logic [15:0] SEED  = 16'hFFFF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            seed_load,
  input  logic [15:0]     seed_data,
  output logic [NREQ-1:0] gnt,
  output logic            rnd_valid,
  output logic [15:0]     rnd_data,
  output logic            busy
`ifdef LFSR_ARB_STATS_EN
  ,
  output logic [15:0]     word_cnt
`endif
);

  localparam int          PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [15:0] CNT_INIT = 16'(STEPS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DELIVER} state_t;

  state_t          state, state_d;
  logic [15:0]     lfsr, lfsr_d;
  logic [15:0]     cnt, cnt_d;
  logic [PW-1:0]   rr_ptr, rr_d;
  logic [PW-1:0]   g, g_d;
  logic [NREQ-1:0] gnt_d;
  logic            valid_d;
  logic [15:0]     rnd_data_d;
  logic [PW-1:0]   sel;
  logic [PW:0]     idx;

  function automatic logic [15:0] lfsr_step(input logic [15:0] q);
    return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  endfunction

  // Round-robin pick: scan offsets from the highest down so the last hit,
  // i.e. the one closest to rr_ptr going upward, wins.
  always_comb begin
    sel = '0;
    idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = {1'b0, rr_ptr} + (PW+1)'(i);
      if (idx >= (PW+1)'(NREQ)) idx = idx - (PW+1)'(NREQ);
      if (req[idx[PW-1:0]]) sel = idx[PW-1:0];
    end
  end

  always_comb begin
    state_d    = state;
    lfsr_d     = lfsr;
    cnt_d      = cnt;
    rr_d       = rr_ptr;
    g_d        = g;
    gnt_d      = '0;
    valid_d    = 1'b0;
    rnd_data_d = rnd_data;
    case (state)
      IDLE: begin
        if (seed_load) lfsr_d = (seed_data == 16'h0000) ? SEED : seed_data;
        if (|req) begin
          g_d     = sel;
          cnt_d   = CNT_INIT;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        lfsr_d = lfsr_step(lfsr);
        cnt_d  = cnt - 16'd1;
        // Outputs are registered, so the pulse is loaded here and shows up
        // while the FSM sits in DELIVER.
        if (cnt == 16'd0) begin
          state_d    = DELIVER;
          gnt_d      = NREQ'(1) << g;
          valid_d    = 1'b1;
          rnd_data_d = lfsr_step(lfsr);
        end
      end
      DELIVER: begin
        rr_d    = (g == PW'(NREQ - 1)) ? '0 : g + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lfsr      <= SEED;
      cnt       <= '0;
      rr_ptr    <= '0;
      g         <= '0;
      gnt       <= '0;
      rnd_valid <= 1'b0;
      rnd_data  <= '0;
    end else begin
      state     <= state_d;
      lfsr      <= lfsr_d;
      cnt       <= cnt_d;
      rr_ptr    <= rr_d;
      g         <= g_d;
      gnt       <= gnt_d;
      rnd_valid <= valid_d;
      rnd_data  <= rnd_data_d;
    end
  end

`ifdef LFSR_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) word_cnt <= '0;
    else if (state == DELIVER) word_cnt <= word_cnt + 16'd1;
  end
`endif

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_lfsr_arb_ctrl.sv
// tb/tb_lfsr_arb_ctrl.sv - scoreboard bench for lfsr_arb_ctrl at STEPS=1 and STEPS=16
module tb_lfsr_arb_ctrl;

  localparam int          NREQ = 4;
  localparam logic [15:0] SEED = 16'hFFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req = '0;
  logic        seed_load = 1'b0;
  logic [15:0] seed_data = '0;

  logic [3:0]  gnt_a, gnt_b;
  logic        val_a, val_b, busy_a, busy_b;
  logic [15:0] dat_a, dat_b;
  logic [15:0] wc_a, wc_b;

  always #5 clk = ~clk;

  lfsr_arb_ctrl #(.NREQ(NREQ), .STEPS(1), .SEED(SEED)) u_a (
    .clk(clk), .reset(reset), .req(req), .seed_load(seed_load), .seed_data(seed_data),
    .gnt(gnt_a), .rnd_valid(val_a), .rnd_data(dat_a), .busy(busy_a)
`ifdef LFSR_ARB_STATS_EN
    , .word_cnt(wc_a)
`endif
  );

  lfsr_arb_ctrl #(.NREQ(NREQ), .STEPS(16), .SEED(SEED)) u_b (
    .clk(clk), .reset(reset), .req(req), .seed_load(seed_load), .seed_data(seed_data),
    .gnt(gnt_b), .rnd_valid(val_b), .rnd_data(dat_b), .busy(busy_b)
`ifdef LFSR_ARB_STATS_EN
    , .word_cnt(wc_b)
`endif
  );

`ifndef LFSR_ARB_STATS_EN
  assign wc_a = '0;
  assign wc_b = '0;
`endif

  typedef struct {
    logic [3:0]  gnt;
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  logic [15:0] m_lfsr[2];
  int          m_rr[2];
  int          m_free[2];
  bit          exp_busy[2];
  logic [15:0] last_data[2];
  int          dcount[2];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int steps_of(input int k);
    return (k == 0) ? 1 : 16;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    logic fb;
    fb = x[15] ^ x[13] ^ x[12] ^ x[10];
    return (x << 1) | {15'd0, fb};
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst=%0d cyc=%0d actual=%h expected=%h", name, k, cyc, act, exp);
    end
  endtask

  task automatic mon(input int k, input logic [3:0] g, input logic v, input logic [15:0] d,
                     input logic b, input logic [15:0] w);
    exp_t e;
    bit   have;
    have = 1'b0;
    if (k == 0 && q0.size() > 0) begin e = q0[0]; have = 1'b1; end
    if (k == 1 && q1.size() > 0) begin e = q1[0]; have = 1'b1; end
    if (v === 1'b1) begin
      if (!have) begin
        chk("unexpected_valid", k, 32'(v), 32'd0);
      end else begin
        if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        chk("gnt", k, 32'(g), 32'(e.gnt));
        chk("rnd_data", k, 32'(d), 32'(e.data));
        chk("latency", k, 32'(cyc), 32'(e.due));
`ifdef LFSR_ARB_STATS_EN
        chk("word_cnt", k, 32'(w), 32'(16'(dcount[k])));
`endif
        dcount[k]++;
        last_data[k] = e.data;
      end
    end else begin
      chk("gnt_idle", k, 32'(g), 32'd0);
      chk("rnd_data_hold", k, 32'(d), 32'(last_data[k]));
      if (have && e.due < cyc) begin
        chk("missing_delivery", k, 32'(cyc), 32'(e.due));
        if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
    end
    chk("busy", k, 32'(b), 32'(exp_busy[k]));
    if (w === 16'hxxxx) chk("word_cnt_known", k, 32'(w), 32'd0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, gnt_a, val_a, dat_a, busy_a, wc_a);
      mon(1, gnt_b, val_b, dat_b, busy_b, wc_b);
    end
  end

  // Drive one cycle of inputs and advance the transaction-level model to the
  // upcoming clock edge. Effects visible only after that edge are applied
  // once the edge has passed, so the monitor never sees them early.
  task automatic step(input logic rst, input logic [3:0] r, input logic sl, input logic [15:0] sd);
    bit   nb[2];
    int   gsel;
    bit   found;
    exp_t e;
    logic [15:0] w;
    reset = rst; req = r; seed_load = sl; seed_data = sd;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_lfsr[k] = SEED; m_rr[k] = 0; m_free[k] = 0;
      end else if (m_free[k] == 0) begin
        if (sl) m_lfsr[k] = (sd == 16'h0) ? SEED : sd;
        if (|r) begin
          found = 1'b0; gsel = 0;
          for (int i = 0; i < NREQ; i++) begin
            if (!found && r[(m_rr[k] + i) % NREQ]) begin
              gsel = (m_rr[k] + i) % NREQ; found = 1'b1;
            end
          end
          w = m_lfsr[k];
          for (int s = 0; s < steps_of(k); s++) w = lfsr_next(w);
          e.gnt = 4'(1 << gsel); e.data = w; e.due = cyc + 1 + steps_of(k);
          if (k == 0) q0.push_back(e); else q1.push_back(e);
          m_lfsr[k] = w;
          m_rr[k] = (gsel + 1) % NREQ;
          m_free[k] = steps_of(k) + 1;
        end
      end else begin
        m_free[k]--;
      end
      nb[k] = (m_free[k] > 0);
    end
    @(posedge clk);
    if (rst) begin
      q0.delete(); q1.delete();
      for (int k = 0; k < 2; k++) begin last_data[k] = '0; dcount[k] = 0; end
      mon_en = 1'b1;
    end
    exp_busy[0] = nb[0];
    exp_busy[1] = nb[1];
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'b0000, 1'b0, 16'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic        rr;
    logic [3:0]  rq;
    logic        rs;
    logic [15:0] rd;
    for (int k = 0; k < 2; k++) begin
      m_lfsr[k] = SEED; m_rr[k] = 0; m_free[k] = 0; exp_busy[k] = 1'b0;
      last_data[k] = '0; dcount[k] = 0;
    end
    @(posedge clk); #1;
    step(1'b1, 4'b0000, 1'b0, 16'h0);
    step(1'b1, 4'b0000, 1'b0, 16'h0);
    idle(2);
    // held single request: FFFE then FFFC at STEPS=1
    repeat (8) step(1'b0, 4'b0001, 1'b0, 16'h0);
    idle(20);
    // seed then request
    step(1'b0, 4'b0000, 1'b1, 16'h0001);
    step(1'b0, 4'b0010, 1'b0, 16'h0);
    idle(20);
    // zero seed replaced by SEED
    step(1'b0, 4'b0000, 1'b1, 16'h0000);
    step(1'b0, 4'b0001, 1'b0, 16'h0);
    idle(20);
    // seed and request in the same cycle
    step(1'b0, 4'b0100, 1'b1, 16'h1234);
    idle(20);
    // all requesting, then a sparse pattern
    repeat (100) step(1'b0, 4'b1111, 1'b0, 16'h0);
    repeat (40) step(1'b0, 4'b1010, 1'b0, 16'h0);
    idle(20);
    // reset in the middle of a long shift
    step(1'b0, 4'b0001, 1'b0, 16'h0);
    idle(5);
    step(1'b1, 4'b0000, 1'b0, 16'h0);
    step(1'b0, 4'b0001, 1'b0, 16'h0);
    idle(20);
    // request dropped and seed_load during shift
    step(1'b0, 4'b0100, 1'b0, 16'h0);
    repeat (3) step(1'b0, 4'b0000, 1'b1, 16'hABCD);
    idle(20);
    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      rr = ($urandom % 150) == 0;
      rq = 4'($urandom);
      rs = ($urandom % 8) == 0;
      rd = (($urandom % 4) == 0) ? 16'h0 : 16'($urandom);
      step(rr, rq, rs, rd);
    end
    idle(40);
    chk("drain", 0, 32'(q0.size() + q1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
